// File: rtl/payoff_accumulator.sv
// Monte-Carlo pricer sink: counts STEPS samples per path, accumulates the European call
// payoff of each terminal sample over 2^LOG2_PATHS paths, then emits the discounted mean.
module payoff_accumulator #(
  parameter int W          = 16,
  parameter int STEPS      = 64,
  parameter int LOG2_PATHS = 10,
  parameter int ACC_W      = W + LOG2_PATHS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  strike,
  input  logic [15:0]   disc,
  input  logic          path_valid,
  input  logic [W-1:0]  path_price,
  output logic          path_ready,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  price_out,
  output logic [1:0]    state_dbg
);

  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0]     LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic [LOG2_PATHS-1:0] LAST_PATH = '1;
  // mean (W bits) * disc (16 bits) + rounding constant needs W+17 bits.
  localparam int PROD_W = W + 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    MEAN  = 2'd2,
    SCALE = 2'd3
  } state_t;

  state_t                state;
  logic [STEP_W-1:0]     step_cnt;
  logic [LOG2_PATHS-1:0] path_cnt;
  logic [ACC_W-1:0]      acc;
  logic [W-1:0]          strike_r;
  logic [15:0]           disc_r;
  logic [W-1:0]          mean_r;

  logic                  xfer;
  logic [W:0]            diff;
  logic [W-1:0]          payoff;
  logic [PROD_W-1:0]     prod;
  logic [W+1:0]          scaled;
  logic [W-1:0]          price_sat;

  // Handshake: a sample moves on a rising edge where path_valid && path_ready;
  // path_ready depends only on the state, never on path_valid.
  always_comb begin
    path_ready = (state == RUN);
    busy       = (state != IDLE);
    state_dbg  = state;
    xfer       = path_valid && (state == RUN);
    diff       = {1'b0, path_price} - {1'b0, strike_r};
    payoff     = diff[W] ? '0 : diff[W-1:0];
    prod       = PROD_W'(mean_r) * PROD_W'(disc_r) + PROD_W'(17'h04000);
    scaled     = prod[PROD_W-1:15];
    price_sat  = (|scaled[W+1:W]) ? '1 : scaled[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_cnt  <= '0;
      path_cnt  <= '0;
      acc       <= '0;
      strike_r  <= '0;
      disc_r    <= '0;
      mean_r    <= '0;
      done      <= 1'b0;
      price_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            strike_r <= strike;
            disc_r   <= disc;
            step_cnt <= '0;
            path_cnt <= '0;
            acc      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (step_cnt != LAST_STEP) begin
              step_cnt <= step_cnt + 1'b1;
            end else begin
              step_cnt <= '0;
              acc      <= acc + ACC_W'(payoff);
              if (path_cnt == LAST_PATH) state <= MEAN;
              else                       path_cnt <= path_cnt + 1'b1;
            end
          end
        end
        MEAN: begin
          mean_r <= W'(acc >> LOG2_PATHS);
          state  <= SCALE;
        end
        SCALE: begin
          price_out <= price_sat;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_payoff_accumulator.sv
// Directed and randomized bench for payoff_accumulator with STEPS=4, LOG2_PATHS=2;
// expected prices come from a plain-arithmetic model of the pricing rules.
module tb_payoff_accumulator;

  localparam int W          = 16;
  localparam int STEPS      = 4;
  localparam int LOG2_PATHS = 2;
  localparam int NPATHS     = 1 << LOG2_PATHS;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_MEAN  = 2'd2;
  localparam logic [1:0] S_SCALE = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  strike;
  logic [15:0]   disc;
  logic          path_valid;
  logic [W-1:0]  path_price;
  logic          path_ready;
  logic          busy;
  logic          done;
  logic [W-1:0]  price_out;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int runs_done = 0;
  int done_cnt = 0;
  logic [15:0] term [NPATHS];

  payoff_accumulator #(.W(W), .STEPS(STEPS), .LOG2_PATHS(LOG2_PATHS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .strike(strike), .disc(disc),
    .path_valid(path_valid), .path_price(path_price), .path_ready(path_ready),
    .busy(busy), .done(done), .price_out(price_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: mean of clamped payoffs, discounted with round-half-up, saturated to 16 bits.
  function automatic logic [15:0] model_price(input logic [15:0] k, input logic [15:0] d);
    longint sum = 0;
    longint mean;
    longint p;
    for (int i = 0; i < NPATHS; i++)
      if (term[i] > k) sum += longint'(term[i]) - longint'(k);
    mean = sum / NPATHS;
    p = (mean * longint'(d) + 16384) / 32768;
    if (p > 65535) p = 65535;
    return p[15:0];
  endfunction

  task automatic send(input logic [15:0] p, input int max_gap);
    int n = 0;
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    path_valid = 1'b1;
    path_price = p;
    while (!path_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", {31'd0, path_ready}, 32'd1);
    @(negedge clk);
    path_valid = 1'b0;
  endtask

  // Called at a negedge; ends at the negedge where done is high.
  task automatic run_est(input string tag, input logic [15:0] k, input logic [15:0] d,
                         input int max_gap, input bit mid_start, input bit hold_valid,
                         input bit rand_fill);
    logic [15:0] exp_p;
    exp_p = model_price(k, d);
    start  = 1'b1;
    strike = k;
    disc   = d;
    @(negedge clk);
    start  = 1'b0;
    strike = ~k;
    disc   = 16'($urandom);
    check({tag, "_run_state"}, {30'd0, state_dbg}, {30'd0, S_RUN});
    check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    for (int p = 0; p < NPATHS; p++) begin
      if (mid_start && p == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int s = 0; s < STEPS - 1; s++)
        send(rand_fill ? 16'($urandom) : 16'h0050, max_gap);
      send(term[p], max_gap);
    end
    if (hold_valid) begin
      path_valid = 1'b1;
      path_price = 16'hFFFF;
    end
    check({tag, "_mean_state"}, {30'd0, state_dbg}, {30'd0, S_MEAN});
    check({tag, "_mean_ready"}, {31'd0, path_ready}, 32'd0);
    check({tag, "_mean_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_mean_done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check({tag, "_scale_state"}, {30'd0, state_dbg}, {30'd0, S_SCALE});
    check({tag, "_scale_ready"}, {31'd0, path_ready}, 32'd0);
    @(negedge clk);
    path_valid = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_price"}, {16'd0, price_out}, {16'd0, exp_p});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    runs_done++;
  endtask

  task automatic set_terms(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] e);
    term[0] = a; term[1] = b; term[2] = c; term[3] = e;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; strike = '0; disc = '0;
    path_valid = 1'b0; path_price = '0;
    repeat (3) @(negedge clk);
    check("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check("rst_ready", {31'd0, path_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_price", {16'd0, price_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 / T2: directed values, back-to-back runs (start in the done cycle)
    set_terms(16'h0200, 16'h0080, 16'h0300, 16'h0100);
    run_est("t1", 16'h0100, 16'h8000, 0, 1'b0, 1'b0, 1'b0);
    check("t1_const", {16'd0, price_out}, 32'h00C0);
    run_est("t2a", 16'h0100, 16'h4000, 0, 1'b0, 1'b0, 1'b0);
    check("t2a_const", {16'd0, price_out}, 32'h0060);
    run_est("t2b", 16'h0100, 16'h6000, 0, 1'b0, 1'b0, 1'b0);
    check("t2b_const", {16'd0, price_out}, 32'h0090);

    // T3: gaps plus extra valid beats after the final terminal
    run_est("t3", 16'h0100, 16'h8000, 5, 1'b0, 1'b1, 1'b0);
    check("t3_const", {16'd0, price_out}, 32'h00C0);
    @(negedge clk);
    check("t3_done_pulse", {31'd0, done}, 32'd0);

    // T4: valid in IDLE ignored, start mid-RUN ignored
    path_valid = 1'b1;
    path_price = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      check("t4_idle_ready", {31'd0, path_ready}, 32'd0);
      check("t4_idle_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    end
    path_valid = 1'b0;
    run_est("t4", 16'h0100, 16'h8000, 2, 1'b1, 1'b0, 1'b0);
    check("t4_const", {16'd0, price_out}, 32'h00C0);

    // T5: reset mid-run after 5 transfers
    @(negedge clk);
    start = 1'b1; strike = 16'h0100; disc = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0300, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_price", {16'd0, price_out}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check("t5_ready", {31'd0, path_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_est("t5_fresh", 16'h0100, 16'h8000, 1, 1'b0, 1'b0, 1'b0);
    check("t5_const", {16'd0, price_out}, 32'h00C0);

    // T6: full scale, saturation, all out of the money
    set_terms(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_est("t6a", 16'h0000, 16'h8000, 0, 1'b0, 1'b0, 1'b0);
    check("t6a_const", {16'd0, price_out}, 32'hFFFF);
    run_est("t6b", 16'h0000, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0);
    check("t6b_const", {16'd0, price_out}, 32'hFFFF);
    set_terms(16'h0200, 16'h0100, 16'h0000, 16'h01FF);
    run_est("t6c", 16'h0200, 16'h8000, 0, 1'b0, 1'b0, 1'b0);
    check("t6c_const", {16'd0, price_out}, 32'h0000);

    // Randomized runs against the model
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NPATHS; i++)
        term[i] = (r == 7) ? 16'($urandom) : 16'($urandom_range(16'h0500, 0));
      run_est($sformatf("rand%0d", r), 16'($urandom_range(16'h0300, 0)),
              16'($urandom), 3, 1'b0, 1'b0, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, runs_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
